// File: rtl/bcd_conv_arbiter_if.sv
// Bundle of the requester-side and converter-side signals of bcd_conv_arbiter.
// The master modport is the arbiter's view; the slave modport is the view of
// the surrounding system (requesters plus the converter).
interface bcd_conv_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // requester side
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] val;
    logic [N_REQ-1:0]   ack;
    logic [3:0]         res_hundreds;
    logic [3:0]         res_tens;
    logic [3:0]         res_ones;
    logic [ID_W-1:0]    res_id;
    logic               busy;
    logic               err;

    // converter side
    logic               cv_start;
    logic [7:0]         cv_in;
    logic [3:0]         cv_hundreds;
    logic [3:0]         cv_tens;
    logic [3:0]         cv_ones;
    logic               cv_done;

    modport master (
        input  req, val, cv_hundreds, cv_tens, cv_ones, cv_done,
        output ack, res_hundreds, res_tens, res_ones, res_id, busy, err,
               cv_start, cv_in
    );

    modport slave (
        output req, val, cv_hundreds, cv_tens, cv_ones, cv_done,
        input  ack, res_hundreds, res_tens, res_ones, res_id, busy, err,
               cv_start, cv_in
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one binary-to-BCD converter between N_REQ
// producers. Drives the converter's level start/done handshake, returns the
// digits with a one-cycle one-hot ack, and aborts a stalled conversion after
// TIMEOUT cycles with a one-cycle err pulse.
module bcd_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              nrst,
    bcd_conv_arbiter_if.master bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gnt_q, gnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               cv_start_q, cv_start_d;
    logic [7:0]         cv_in_q, cv_in_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [3:0]         res_h_q, res_h_d;
    logic [3:0]         res_t_q, res_t_d;
    logic [3:0]         res_o_q, res_o_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;

    logic               found;
    logic [ID_W-1:0]    pick;
    logic [7:0]         pick_val;
    logic [N_REQ-1:0]   rot;

    // requester index following g, wrapping at N_REQ (N_REQ need not be a power of two)
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] g);
        if (int'(g) >= N_REQ - 1) return '0;
        return g + ID_W'(1);
    endfunction

    // round-robin search: rotate req so ptr sits at bit 0, take the lowest set bit
    always_comb begin
        int p;
        found    = 1'b0;
        pick     = '0;
        pick_val = '0;
        p        = 0;
        rot      = N_REQ'({bus.req, bus.req} >> ptr_q);
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                p     = int'(ptr_q) + i;
                if (p >= N_REQ) p = p - N_REQ;
                pick  = ID_W'(p);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == pick) pick_val = bus.val[8*i +: 8];
        end
    end

    // next-state and registered-output logic of the IDLE/WAIT_DONE/RELEASE sequencer
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        tmo_d      = tmo_q;
        cv_start_d = cv_start_q;
        cv_in_d    = cv_in_q;
        ack_d      = '0;
        err_d      = 1'b0;
        res_h_d    = res_h_q;
        res_t_d    = res_t_q;
        res_o_d    = res_o_q;
        res_id_d   = res_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = pick;
                    cv_in_d    = pick_val;
                    cv_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.cv_done) begin
                    res_h_d    = bus.cv_hundreds;
                    res_t_d    = bus.cv_tens;
                    res_o_d    = bus.cv_ones;
                    res_id_d   = gnt_q;
                    for (int i = 0; i < N_REQ; i++) ack_d[i] = (ID_W'(i) == gnt_q);
                    cv_start_d = 1'b0;
                    ptr_d      = next_id(gnt_q);
                    tmo_d      = '0;
                    state_d    = RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    cv_start_d = 1'b0;
                    err_d      = 1'b1;
                    ptr_d      = next_id(gnt_q);
                    tmo_d      = '0;
                    state_d    = RELEASE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RELEASE: begin
                // wait for done to drop so the next grant never sees a stale done
                if (!bus.cv_done) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and output registers, all cleared asynchronously
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            tmo_q      <= '0;
            cv_start_q <= 1'b0;
            cv_in_q    <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            res_h_q    <= '0;
            res_t_q    <= '0;
            res_o_q    <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            tmo_q      <= tmo_d;
            cv_start_q <= cv_start_d;
            cv_in_q    <= cv_in_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            res_h_q    <= res_h_d;
            res_t_q    <= res_t_d;
            res_o_q    <= res_o_d;
            res_id_q   <= res_id_d;
        end
    end

    assign bus.cv_start     = cv_start_q;
    assign bus.cv_in        = cv_in_q;
    assign bus.ack          = ack_q;
    assign bus.err          = err_q;
    assign bus.busy         = busy_q;
    assign bus.res_hundreds = res_h_q;
    assign bus.res_tens     = res_t_q;
    assign bus.res_ones     = res_o_q;
    assign bus.res_id       = res_id_q;
endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one 8-bit binary-to-BCD converter between up to N_REQ display-value producers. It sits between the value sources (sensor readouts, counters, menu fields) and the single converter instance feeding the Nokia 5110 digit-bitmap RAM indexer. It drives the converter's level start/done handshake, returns digits plus requester id with a one-cycle ack, and recovers from a stalled converter via timeout.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- TIMEOUT, default 64: max cycles waited in WAIT_DONE or RELEASE before abort, ≥ 32.
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester level request; held until ack.
- val  in  8*N_REQ  per-requester value; slice i = val[8i+7:8i]; stable while req[i]=1.
- ack  out  N_REQ  one-hot, one-cycle pulse: result for that requester valid.
- res_hundreds, res_tens, res_ones  out  4 each  BCD digits of last completed conversion.
- res_id  out  $clog2(N_REQ)  requester of last completed conversion.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on timeout abort.
- cv_start  out  1  converter start, level.
- cv_in  out  8  converter operand.
- cv_hundreds, cv_tens, cv_ones  in  4 each  converter digits.
- cv_done  in  1  converter done, level; falls only after cv_start low.

## Operation
- States: IDLE, WAIT_DONE, RELEASE. Registered outputs throughout.
- IDLE: if req≠0, grant first set bit searching from ptr upward, wrapping mod N_REQ. Register cv_in←val[grant], gnt←grant, cv_start←1, tmo←0; go WAIT_DONE. req is sampled only in IDLE.
- WAIT_DONE: cv_start and cv_in held. tmo increments each cycle.
  - cv_done=1: res_*←cv_*, res_id←gnt, ack[gnt]←1 for one cycle, cv_start←0, ptr←(gnt+1) mod N_REQ, tmo←0; go RELEASE.
  - else tmo=TIMEOUT-1: cv_start←0, err←1 for one cycle, ptr←(gnt+1) mod N_REQ, tmo←0, no ack, res_* unchanged; go RELEASE.
- RELEASE: cv_start=0. cv_done=0 → IDLE. Else tmo=TIMEOUT-1 → err pulse, IDLE.
- ptr advances past the granted requester on ack and on abort, so a requester holding req after ack or abort is served again only after all other pending requesters.
- res_hundreds passes through unchanged; for inputs 200..255 it is converter-defined and not interpreted here.
- Reset (any time, incl. mid-conversion): state IDLE, ptr=0, gnt=0, tmo=0; cv_start=0, cv_in=0, ack=0, err=0, busy=0, res_*=0, res_id=0. No ack for the interrupted request.

## Timing
- Grant: req seen in IDLE at edge k → cv_start=1 and cv_in valid after edge k.
- Result: cv_done first seen high at edge m → ack, res_*, res_id valid after edge m; res_* hold until the next ack.
- ack and err are never high together. ack is never followed by another ack in fewer than 3 cycles: RELEASE ≥1 cycle plus IDLE ≥1 cycle.
- cv_done already high on entry to WAIT_DONE is accepted. The converter must not present stale done; the RELEASE wait guarantees this.
- Requester obligation: drop req within 1 cycle of ack or err, unless another conversion is wanted.
- Back-to-back throughput: converter latency + 3 cycles per conversion, minimum.

## Test plan
- Single req[1], val=176, converter model latency 25 → cv_in=176; ack=0010 one cycle; res_id=1, hundreds=1, tens=7, ones=6; busy low 1 cycle after cv_done falls.
- req=1111 simultaneously, values 0,9,99,255 → acks in order 0,1,2,3; digits 0/0/0, 0/0/9, 0/9/9, 2/5/5 per converter model.
- req[0] and req[2] held continuously → grants alternate 0,2,0,2; req[1] raised later is served before the next grant to 0 once ptr passes 1.
- Converter model never raises cv_done → err pulses exactly TIMEOUT cycles after cv_start rises; no ack; cv_start low; next pending requester granted.
- nrst asserted mid-WAIT_DONE → cv_start, ack, busy low immediately (async). After release, req honoured from requester 0 with no spurious ack.
